spi_slave_axi_burst_sched: RTL and testbench
============================================

Name: spi_slave_axi_burst_sched

Overview:
- Burst scheduler between the SPI slave controller/synchroniser and the AXI master plug, in the AXI clock domain.
- Takes one transfer command (start address, word count, direction) and splits it into AXI INCR bursts of 32-bit beats.
- Each burst is limited by the remaining words, MAX_BURST and the AXI 4 KB boundary.
- Issues the bursts one at a time, waits for each to complete, handles chip-select abort, and signals transfer completion.

Parameters:
- AXI_ADDR_WIDTH, 32, width of command and burst addresses.
- MAX_BURST, 16, maximum beats per burst (1..256).
- BEAT_BYTES, 4, bytes per beat; fixed 32-bit words; address step per beat.

Ports:
- axi_aclk  in  1  AXI clock; the only clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  transfer command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; bits [1:0] ignored (treated 0).
- cmd_words  in  16  number of 32-bit words; 0 means an empty transfer.
- cmd_rd_wr  in  1  1 = read from AXI, 0 = write to AXI.
- cs  in  1  synchronised SPI chip select; 1 = deselected (abort request).
- burst_valid  out  1  burst request to the AXI plug.
- burst_ready  in  1  plug accepts the burst.
- burst_addr  out  AXI_ADDR_WIDTH  burst start address (word aligned).
- burst_len  out  8  beats minus 1 (AXI len encoding).
- burst_rd_wr  out  1  direction of the current burst.
- burst_done  in  1  single-cycle pulse: last R beat received, or B response received.
- busy  out  1  state != IDLE.
- xfer_done  out  1  single-cycle pulse at end of transfer.
- xfer_aborted  out  1  qualifies xfer_done; 1 when the transfer ended early due to cs.

Behaviour:
- Reset values: burst_valid 0, burst_addr 0, burst_len 0, burst_rd_wr 0, busy 0, xfer_done 0, xfer_aborted 0.
- State resets to IDLE, so cmd_ready = 1 while reset is held.
- States: IDLE, CALC, ISSUE, WAIT, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch addr (with [1:0] = 0), remaining = cmd_words, dir = cmd_rd_wr; clear the abort flag; go to CALC.
- CALC:
  - If remaining == 0 or the abort flag is set, go to DONE.
  - Otherwise: to4k = (4096 − addr[11:0]) / BEAT_BYTES; n = min(remaining, MAX_BURST, to4k).
  - Register burst_addr = addr, burst_len = n − 1, burst_rd_wr = dir; go to ISSUE.
- ISSUE:
  - burst_valid = 1; burst_addr, burst_len and burst_rd_wr stay stable until burst_ready.
  - On burst_ready: addr += n·BEAT_BYTES (modulo 2^AXI_ADDR_WIDTH); remaining −= n; go to WAIT.
  - burst_valid drops the cycle after acceptance. It is never retracted early, even if cs rises.
- WAIT:
  - On burst_done, go to CALC.
  - burst_done is ignored in every other state.
- DONE:
  - xfer_done = 1 for exactly one cycle; xfer_aborted = abort flag.
  - Go to IDLE.
- Abort flag:
  - Set whenever cs == 1 while busy.
  - An in-flight or already-presented burst always completes; no new burst is issued afterwards.
  - Abort during CALC goes to DONE immediately.
- Latency:
  - Command accepted at cycle T → CALC at T+1 → burst_valid first high at T+2.
  - burst_done at cycle D → next burst_valid at D+2, or xfer_done at D+2.
  - Empty transfer: xfer_done at T+2.
- Simultaneous cs rise and burst_done in WAIT: the abort takes effect, so no further burst is issued.
- cmd_valid outside IDLE is not accepted (cmd_ready = 0).
- A burst never crosses a 4 KB boundary and never exceeds MAX_BURST beats; the sum of all beats equals cmd_words unless aborted.
- Asynchronous reset mid-transfer: immediate return to IDLE with all outputs at reset values; no xfer_done is generated.

Test Plan:
- Write, addr 0x1000_0000, 40 words, MAX_BURST 16 → three bursts:
  - (0x1000_0000, len 15), (0x1000_0040, len 15), (0x1000_0080, len 7);
  - xfer_done=1, xfer_aborted=0 two cycles after the 3rd burst_done.
- Read, addr 0x0000_0FF0, 8 words → (0x0FF0, len 3, rd_wr 1), then (0x1000, len 3); no burst crosses the 4 KB boundary.
- cmd_words 0, accepted at T → no burst_valid; xfer_done pulse at T+2, busy high T+1..T+2.
- 40-word write; cs=1 during WAIT of the first burst → after its burst_done, no second burst; xfer_done with xfer_aborted=1.
- burst_ready held 0 for 5 cycles → burst_valid stays 1 with addr/len unchanged; single acceptance only; cs toggling during the stall does not drop burst_valid.
- axi_aresetn pulsed low during WAIT → outputs at reset values immediately, cmd_ready=1, no xfer_done; a new command afterwards runs normally.

Source files
------------

// File: rtl/spi_slave_axi_burst_sched.sv
// Burst scheduler: splits one SPI transfer command into AXI INCR bursts that
// respect MAX_BURST and the 4 KB boundary, issuing them one at a time.
module spi_slave_axi_burst_sched #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned BEAT_BYTES     = 4
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]               cmd_words,
  input  logic                      cmd_rd_wr,
  input  logic                      cs,
  output logic                      burst_valid,
  input  logic                      burst_ready,
  output logic [AXI_ADDR_WIDTH-1:0] burst_addr,
  output logic [7:0]                burst_len,
  output logic                      burst_rd_wr,
  input  logic                      burst_done,
  output logic                      busy,
  output logic                      xfer_done,
  output logic                      xfer_aborted
);

  localparam int unsigned WORDS_W    = 16;
  localparam int unsigned N_W        = 9;
  localparam int unsigned SPAN_W     = 17;
  localparam int unsigned PAGE_W     = 13;
  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [WORDS_W-1:0]        rem_q;
  logic                      dir_q;
  logic                      abort_q;
  logic [N_W-1:0]            n_q;
  logic [SPAN_W-1:0]         to4k_c;
  logic [SPAN_W-1:0]         n_c;

  // Beats for the next burst: min(remaining, MAX_BURST, beats left in the 4 KB page)
  always_comb begin
    to4k_c = SPAN_W'((PAGE_W'(PAGE_BYTES) - {1'b0, addr_q[11:0]}) / PAGE_W'(BEAT_BYTES));
    n_c    = SPAN_W'(rem_q);
    if (n_c > SPAN_W'(MAX_BURST)) n_c = SPAN_W'(MAX_BURST);
    if (n_c > to4k_c)             n_c = to4k_c;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    burst_valid  = 1'b0;
    xfer_done    = 1'b0;
    xfer_aborted = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = S_CALC;
      end
      S_CALC: begin
        // A cs seen in this very cycle counts as an abort too
        if (rem_q == '0 || abort_q || cs) state_d = S_DONE;
        else                              state_d = S_ISSUE;
      end
      S_ISSUE: begin
        burst_valid = 1'b1;
        if (burst_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (burst_done) state_d = S_CALC;
      end
      S_DONE: begin
        xfer_done    = 1'b1;
        xfer_aborted = abort_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer bookkeeping and the registered burst descriptor
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      addr_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      abort_q     <= 1'b0;
      n_q         <= '0;
      burst_addr  <= '0;
      burst_len   <= '0;
      burst_rd_wr <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr & ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
            rem_q   <= cmd_words;
            dir_q   <= cmd_rd_wr;
            abort_q <= 1'b0;
          end
        end
        S_CALC: begin
          if (state_d == S_ISSUE) begin
            burst_addr  <= addr_q;
            burst_len   <= 8'(n_c - SPAN_W'(1));
            burst_rd_wr <= dir_q;
            n_q         <= N_W'(n_c);
          end
        end
        S_ISSUE: begin
          if (burst_ready) begin
            addr_q <= addr_q + AXI_ADDR_WIDTH'(32'(n_q) * BEAT_BYTES);
            rem_q  <= rem_q - WORDS_W'(n_q);
          end
        end
        default: ;
      endcase
      if (state_q != S_IDLE && cs) abort_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_axi_burst_sched.sv
// Directed bench for spi_slave_axi_burst_sched: burst splitting, 4 KB page
// handling, empty transfer, cs abort, stalled acceptance and async reset.
module tb_spi_slave_axi_burst_sched;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic        cmd_rd_wr;
  logic        cs;
  logic        burst_valid;
  logic        burst_ready;
  logic [31:0] burst_addr;
  logic [7:0]  burst_len;
  logic        burst_rd_wr;
  logic        burst_done;
  logic        busy;
  logic        xfer_done;
  logic        xfer_aborted;

  int n_pass = 0;
  int n_total = 0;

  spi_slave_axi_burst_sched #(
    .AXI_ADDR_WIDTH(32),
    .MAX_BURST(16),
    .BEAT_BYTES(4)
  ) dut (
    .axi_aclk(axi_aclk),
    .axi_aresetn(axi_aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_words(cmd_words),
    .cmd_rd_wr(cmd_rd_wr),
    .cs(cs),
    .burst_valid(burst_valid),
    .burst_ready(burst_ready),
    .burst_addr(burst_addr),
    .burst_len(burst_len),
    .burst_rd_wr(burst_rd_wr),
    .burst_done(burst_done),
    .busy(busy),
    .xfer_done(xfer_done),
    .xfer_aborted(xfer_aborted)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a command; returns at cycle T+2 (first burst_valid or xfer_done)
  task automatic send_cmd(input string tag, input logic [31:0] a, input logic [15:0] w,
                          input logic rw);
    cmd_addr  = a;
    cmd_words = w;
    cmd_rd_wr = rw;
    cmd_valid = 1'b1;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
    chk({tag, "_cmd_ready_t1"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_valid_t1"}, 32'(burst_valid), 32'd0);
    tick();
  endtask

  // At a cycle where a burst must be presented: check it, accept, complete it.
  // Returns at D+2 relative to the burst_done pulse.
  task automatic do_burst(input string tag, input logic [31:0] a, input logic [7:0] l,
                          input logic rw);
    chk({tag, "_valid"}, 32'(burst_valid), 32'd1);
    chk({tag, "_addr"}, burst_addr, a);
    chk({tag, "_len"}, 32'(burst_len), 32'(l));
    chk({tag, "_rw"}, 32'(burst_rd_wr), 32'(rw));
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(burst_valid), 32'd0);
    tick();
    chk({tag, "_valid_wait"}, 32'(burst_valid), 32'd0);
    tick();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk({tag, "_valid_d1"}, 32'(burst_valid), 32'd0);
    tick();
  endtask

  task automatic expect_done(input string tag, input logic aborted);
    chk({tag, "_xfer_done"}, 32'(xfer_done), 32'd1);
    chk({tag, "_xfer_aborted"}, 32'(xfer_aborted), 32'(aborted));
    chk({tag, "_no_burst"}, 32'(burst_valid), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(xfer_done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    axi_aresetn = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_words   = '0;
    cmd_rd_wr   = 1'b0;
    cs          = 1'b0;
    burst_ready = 1'b0;
    burst_done  = 1'b0;

    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valid", 32'(burst_valid), 32'd0);
    chk("rst_addr", burst_addr, 32'd0);
    chk("rst_len", 32'(burst_len), 32'd0);
    chk("rst_rw", 32'(burst_rd_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(xfer_done), 32'd0);
    chk("rst_aborted", 32'(xfer_aborted), 32'd0);
    tick();
    axi_aresetn = 1'b1;
    tick();

    // 40-word write splits into 16 + 16 + 8
    send_cmd("w40", 32'h1000_0000, 16'd40, 1'b0);
    do_burst("w40_b0", 32'h1000_0000, 8'd15, 1'b0);
    do_burst("w40_b1", 32'h1000_0040, 8'd15, 1'b0);
    do_burst("w40_b2", 32'h1000_0080, 8'd7, 1'b0);
    expect_done("w40", 1'b0);

    // Read starting 16 bytes below a 4 KB boundary; low address bits ignored
    send_cmd("r8", 32'h0000_0FF3, 16'd8, 1'b1);
    do_burst("r8_b0", 32'h0000_0FF0, 8'd3, 1'b1);
    do_burst("r8_b1", 32'h0000_1000, 8'd3, 1'b1);
    expect_done("r8", 1'b0);

    // Empty transfer
    send_cmd("empty", 32'h2000_0000, 16'd0, 1'b0);
    chk("empty_busy_t2", 32'(busy), 32'd1);
    expect_done("empty", 1'b0);

    // cs rises during WAIT of the first burst
    send_cmd("ab", 32'h1000_0000, 16'd40, 1'b0);
    chk("ab_addr", burst_addr, 32'h1000_0000);
    chk("ab_len", 32'(burst_len), 32'd15);
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    cs = 1'b1;
    tick();
    cs = 1'b0;
    tick();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("ab_valid_d1", 32'(burst_valid), 32'd0);
    tick();
    expect_done("ab", 1'b1);

    // cs and burst_done in the same cycle
    send_cmd("ab2", 32'h1000_0000, 16'd40, 1'b1);
    chk("ab2_valid", 32'(burst_valid), 32'd1);
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    tick();
    cs = 1'b1;
    burst_done = 1'b1;
    tick();
    cs = 1'b0;
    burst_done = 1'b0;
    chk("ab2_valid_d1", 32'(burst_valid), 32'd0);
    tick();
    expect_done("ab2", 1'b1);

    // Stalled acceptance with cs toggling: burst stays presented and stable
    send_cmd("st", 32'h2000_0100, 16'd20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cs = (i == 1 || i == 2);
      chk("st_valid", 32'(burst_valid), 32'd1);
      chk("st_addr", burst_addr, 32'h2000_0100);
      chk("st_len", 32'(burst_len), 32'd15);
      tick();
    end
    cs = 1'b0;
    chk("st_valid_end", 32'(burst_valid), 32'd1);
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    chk("st_single_accept", 32'(burst_valid), 32'd0);
    tick();
    chk("st_still_low", 32'(burst_valid), 32'd0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    tick();
    expect_done("st", 1'b1);

    // Asynchronous reset while waiting on a burst
    send_cmd("rs", 32'h1000_0000, 16'd40, 1'b1);
    chk("rs_valid", 32'(burst_valid), 32'd1);
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    #2;
    axi_aresetn = 1'b0;
    #1;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rs_addr", burst_addr, 32'd0);
    chk("rs_len", 32'(burst_len), 32'd0);
    chk("rs_rw", 32'(burst_rd_wr), 32'd0);
    chk("rs_done", 32'(xfer_done), 32'd0);
    tick();
    axi_aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rs_no_done", 32'(xfer_done), 32'd0);
      chk("rs_no_valid", 32'(burst_valid), 32'd0);
      tick();
    end
    send_cmd("rs_new", 32'h3000_0000, 16'd4, 1'b1);
    do_burst("rs_new_b0", 32'h3000_0000, 8'd3, 1'b1);
    expect_done("rs_new", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
